// File: rtl/tile_ram_arbiter_pkg.sv
// Shared defaults and FSM state encoding for the tile colour RAM arbiter.
package tile_ram_arbiter_pkg;

    localparam int ADDR_W_DEF     = 6;
    localparam int DATA_W_DEF     = 24;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_DISP   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_IDLE   = 2'd2,
        ST_WRITE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/tile_wr_fifo.sv
// Host write queue: synchronous FIFO with push/pop, full/empty flags and an occupancy count.
module tile_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Push is refused while full even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is not reset; cleared pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Tile colour RAM arbiter: display reads own the RAM in active video, queued host writes drain in blanking.
// Define TILE_ARB_TEAR_FREE_EN to restrict draining to vertical blanking only.
module tile_ram_arbiter
    import tile_ram_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          video_active,
    input  logic                          vSync,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic [DATA_W-1:0]             disp_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic                          ram_we,
    input  logic [DATA_W-1:0]             ram_q,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
`ifdef TILE_ARB_TEAR_FREE_EN
    localparam bit TEAR_FREE = 1'b1;
`else
    localparam bit TEAR_FREE = 1'b0;
`endif

    arb_state_t               state;
    logic                     va_q;
    logic                     vb_arm;
    logic                     drain_ok;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [ADDR_W+DATA_W-1:0] head;

    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready;
    assign drain_ok = !TEAR_FREE || vb_arm;

    // Active video overrides the FSM combinationally so an in-flight write aborts without popping.
    assign ram_we    = (state == ST_WRITE) && !video_active && drain_ok;
    assign pop       = ram_we;
    assign ram_addr  = ram_we ? head[ADDR_W+DATA_W-1:DATA_W] : disp_addr;
    assign ram_wdata = head[DATA_W-1:0];

    tile_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({wr_addr, wr_data}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_DISP;
            va_q      <= 1'b0;
            vb_arm    <= 1'b0;
            disp_data <= '0;
        end else begin
            // va_q marks the cycle whose RAM read was issued during active video.
            va_q <= video_active;
            if (va_q) disp_data <= ram_q;

            if (video_active && !va_q) vb_arm <= 1'b0;
            else if (vSync)            vb_arm <= 1'b1;

            if (video_active) begin
                state <= ST_DISP;
            end else begin
                case (state)
                    ST_DISP:   state <= ST_SETTLE;
                    ST_SETTLE: state <= (!empty && drain_ok) ? ST_WRITE : ST_IDLE;
                    ST_IDLE:   if (!empty && drain_ok) state <= ST_WRITE;
                    ST_WRITE:  if (pop && !push && fifo_level == LVL_W'(1)) state <= ST_IDLE;
                    default:   state <= ST_DISP;
                endcase
            end
        end
    end

endmodule
